// File: rtl/mem_request_ctrl.sv
// Sequences instruction fetch and data access for a single-issue core, retiring one
// instruction per completed fetch (ALU/branch) or data access, and stopping on HALT or timeout.
module mem_request_ctrl #(
  parameter int TIMEOUT_CYC = 255,
  parameter int RET_W       = 32,
  parameter int WAIT_W      = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             DatRead,
  input  logic             DatWrite,
  input  logic             HaltReq,
  input  logic             ihit,
  input  logic             dhit,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             pc_en,
  output logic             halt,
  output logic             mem_err,
  output logic [RET_W-1:0] retired
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2,
    ERROR  = 2'd3
  } state_t;

  // The counter only ever needs to hold TIMEOUT_CYC-1: the miss that would reach
  // TIMEOUT_CYC is the one that moves the machine to ERROR.
  localparam logic [WAIT_W-1:0] LP_WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait;
  logic              r_is_write;
  logic [RET_W-1:0]  r_retired;
  logic              r_halt;
  logic              r_mem_err;

  logic w_in_fetch;
  logic w_in_data;
  logic w_fetch_hit;
  logic w_data_hit;
  logic w_hit;
  logic w_data_op;
  logic w_retire;
  logic w_timeout;

  assign w_in_fetch  = (r_state == FETCH);
  assign w_in_data   = (r_state == DATA);
  assign w_fetch_hit = w_in_fetch & ihit;
  assign w_data_hit  = w_in_data & dhit;
  assign w_hit       = w_fetch_hit | w_data_hit;
  assign w_data_op   = DatRead | DatWrite;
  assign w_retire    = (w_fetch_hit & ~HaltReq & ~w_data_op) | w_data_hit;
  assign w_timeout   = (w_in_fetch | w_in_data) & ~w_hit & (r_wait == LP_WAIT_LAST);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= FETCH;
      r_wait     <= '0;
      r_is_write <= 1'b0;
      r_retired  <= '0;
      r_halt     <= 1'b0;
      r_mem_err  <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (ihit) begin
            r_wait <= '0;
            if (HaltReq) begin
              r_state <= HALTED;
              r_halt  <= 1'b1;
            end else if (w_data_op) begin
              r_state    <= DATA;
              r_is_write <= DatWrite;
            end else begin
              r_retired <= r_retired + RET_W'(1);
            end
          end else if (w_timeout) begin
            r_state   <= ERROR;
            r_wait    <= '0;
            r_halt    <= 1'b1;
            r_mem_err <= 1'b1;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        DATA: begin
          if (dhit) begin
            r_state   <= FETCH;
            r_wait    <= '0;
            r_retired <= r_retired + RET_W'(1);
          end else if (w_timeout) begin
            r_state   <= ERROR;
            r_wait    <= '0;
            r_halt    <= 1'b1;
            r_mem_err <= 1'b1;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        HALTED, ERROR: begin
          r_wait <= '0;
        end
      endcase
    end
  end

  // pc_en is gated by reset so a stray ihit while nRST is low cannot advance the PC.
  assign imemREN = w_in_fetch;
  assign dmemREN = w_in_data & ~r_is_write;
  assign dmemWEN = w_in_data & r_is_write;
  assign pc_en   = nRST & w_retire;
  assign halt    = r_halt;
  assign mem_err = r_mem_err;
  assign retired = r_retired;

endmodule
